// File: rtl/mover_derecha_pkg.sv
// Shared definitions for the right-shift path: FSM encodings and default sizing.
// Also used by the ALU top and the left-shift bench.
package mover_derecha_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int DEFAULT_SHW   = $clog2(DEFAULT_WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/mover_derecha_paso.sv
// Single combinational right-shift step: returns {fill, sreg[WIDTH-1:1]}.
module mover_derecha_paso
    import mover_derecha_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] sreg_i,
    input  logic             fill_i,
    output logic [WIDTH-1:0] sreg_o
);

    // Written as a shift/or so every input bit is consumed.
    always_comb begin
        sreg_o = (sreg_i >> 1) | ({{(WIDTH-1){1'b0}}, fill_i} << (WIDTH-1));
    end

endmodule

// File: rtl/mover_derecha_secuencial.sv
// Sequential right shifter, one bit per clock, start/busy/done handshake.
// Define MOVER_DERECHA_ARIT_EN for arithmetic (sign-filling) shifts; default is logical.
module mover_derecha_secuencial
    import mover_derecha_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [SHW-1:0]   B,
    output logic [WIDTH-1:0] E,
    output logic             busy,
    output logic             done,
    output state_t           state_dbg
);

    // Handshake: start is sampled only in IDLE; E and done update together
    // B+1 edges after the accepting edge, and done is high for one cycle.
    localparam int CW = $clog2(WIDTH + 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [WIDTH-1:0] e_q, e_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    load_cnt;
    logic             done_q, done_d;
    logic             fill;
    logic [WIDTH-1:0] step;

`ifdef MOVER_DERECHA_ARIT_EN
    // The MSB never changes under an arithmetic shift, so it is the sign of captured A.
    assign fill = sreg_q[WIDTH-1];
`else
    assign fill = 1'b0;
`endif

    mover_derecha_paso #(.WIDTH(WIDTH)) u_paso (
        .sreg_i (sreg_q),
        .fill_i (fill),
        .sreg_o (step)
    );

    always_comb begin
        if (32'(B) >= WIDTH) load_cnt = CW'(WIDTH);
        else                 load_cnt = CW'(B);
    end

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        e_d     = e_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sreg_d  = A;
                    cnt_d   = load_cnt;
                    state_d = (load_cnt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                sreg_d = step;
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = DONE;
            end
            DONE: begin
                e_d     = sreg_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            e_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            e_q     <= e_d;
            done_q  <= done_d;
        end
    end

    assign E         = e_q;
    assign done      = done_q;
    assign busy      = (state_q == SHIFT) || (state_q == DONE);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_mover_derecha_secuencial.sv
// Directed bench for mover_derecha_secuencial (4-bit default build).
// Expected values follow MOVER_DERECHA_ARIT_EN when it is defined.
module tb_mover_derecha_secuencial;
    import mover_derecha_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] a_in;
    logic [1:0] b_in;
    logic [3:0] e_out;
    logic       busy;
    logic       done;
    state_t     state_dbg;

    int n_vec = 0;
    int n_err = 0;
    logic [3:0] exp_q[$];

    mover_derecha_secuencial dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .A         (a_in),
        .B         (b_in),
        .E         (e_out),
        .busy      (busy),
        .done      (done),
        .state_dbg (state_dbg)
    );

    // Clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] model(input logic [3:0] a, input int b);
`ifdef MOVER_DERECHA_ARIT_EN
        return 4'($signed(a) >>> b);
`else
        return a >> b;
`endif
    endfunction

    // Driver: one operation, latency and result checked against the scoreboard.
    task automatic run_op(input logic [3:0] a, input logic [1:0] b);
        int n;
        logic [3:0] exp;
        exp_q.push_back(model(a, int'(b)));
        start = 1'b1; a_in = a; b_in = b;
        tick();
        start = 1'b0;
        a_in = 4'($urandom_range(0, 15));
        b_in = 2'($urandom_range(0, 3));
        check("busy_after_accept", 32'(busy), 32'd1);
        n = 0;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        check("latency", 32'(n), 32'(int'(b) + 1));
        exp = exp_q.pop_front();
        check("result", 32'(e_out), 32'(exp));
        tick();
        check("done_single", 32'(done), 32'd0);
        check("e_hold", 32'(e_out), 32'(exp));
    endtask

    initial begin
        int ndone, first;
        logic [3:0] e_at;
        logic [3:0] e_seen[2];
        int d_idx[2];

        // Reset with start held high
        rst_n = 1'b0; start = 1'b1; a_in = 4'hF; b_in = 2'd1;
        tick();
        tick();
        check("rst_e", 32'(e_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(IDLE));
        start = 1'b0; rst_n = 1'b1;
        tick();
        check("post_rst_busy", 32'(busy), 32'd0);

        // Directed example, then every A/B pair
        run_op(4'hD, 2'd1);
`ifndef MOVER_DERECHA_ARIT_EN
        check("ex_d_1", 32'(e_out), 32'h6);
`endif
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 4; b++)
                run_op(4'(a), 2'(b));

`ifdef MOVER_DERECHA_ARIT_EN
        run_op(4'b1010, 2'd1);
        check("arit_1010", 32'(e_out), 32'b1101);
        run_op(4'b0110, 2'd2);
        check("arit_0110", 32'(e_out), 32'b0001);
        run_op(4'b1000, 2'd2);
        check("arit_1000", 32'(e_out), 32'b1110);
`else
        run_op(4'b1000, 2'd2);
        check("log_1000", 32'(e_out), 32'b0010);
`endif

        // Start pulsed while busy must be ignored
        start = 1'b1; a_in = 4'hF; b_in = 2'd3;
        tick();
        ndone = 0; first = 0; e_at = 4'h0;
        for (int i = 1; i <= 10; i++) begin
            if (i == 2) begin
                start = 1'b1; a_in = 4'h1; b_in = 2'd0;
            end else begin
                start = 1'b0;
            end
            tick();
            if (done) begin
                ndone++;
                if (first == 0) begin
                    first = i;
                    e_at = e_out;
                end
            end
        end
        check("busy_ign_count", 32'(ndone), 32'd1);
        check("busy_ign_lat", 32'(first), 32'd4);
        check("busy_ign_e", 32'(e_at), 32'(model(4'hF, 3)));

        // Reset during the second SHIFT cycle
        start = 1'b1; a_in = 4'hC; b_in = 2'd3;
        tick();
        start = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        check("midrst_e", 32'(e_out), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done) ndone++;
        end
        check("midrst_no_done", 32'(ndone), 32'd0);

        // Back-to-back with start held high
        start = 1'b1; a_in = 4'h8; b_in = 2'd2;
        tick();
        a_in = 4'h8; b_in = 2'd0;
        ndone = 0;
        d_idx[0] = 0; d_idx[1] = 0;
        e_seen[0] = 4'h0; e_seen[1] = 4'h0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (done && ndone < 2) begin
                d_idx[ndone] = i;
                e_seen[ndone] = e_out;
                ndone++;
            end
            if (i == 4) begin
                check("b2b_gap_done", 32'(done), 32'd0);
`ifdef MOVER_DERECHA_ARIT_EN
                check("b2b_gap_e", 32'(e_out), 32'hE);
`else
                check("b2b_gap_e", 32'(e_out), 32'h2);
`endif
            end
        end
        start = 1'b0;
        check("b2b_first_idx", 32'(d_idx[0]), 32'd3);
        check("b2b_second_idx", 32'(d_idx[1]), 32'd5);
`ifdef MOVER_DERECHA_ARIT_EN
        check("b2b_first_e", 32'(e_seen[0]), 32'hE);
`else
        check("b2b_first_e", 32'(e_seen[0]), 32'h2);
`endif
        check("b2b_second_e", 32'(e_seen[1]), 32'h8);
        for (int i = 0; i < 4; i++) tick();
        check("drain_busy", 32'(busy), 32'd0);

        // Final report
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
